// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the issue scheduler: RV32I major opcodes,
// boolean constants, default resource sizes, FIFO entry layout and
// the per-opcode resource classification helper.
package issue_scheduler_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // RV32I major opcodes (instruction bits [6:0])
    localparam logic [6:0] LUIOP   = 7'b0110111;
    localparam logic [6:0] AUIPCOP = 7'b0010111;
    localparam logic [6:0] JALOP   = 7'b1101111;
    localparam logic [6:0] JALROP  = 7'b1100111;
    localparam logic [6:0] BROP    = 7'b1100011;
    localparam logic [6:0] LOP     = 7'b0000011;
    localparam logic [6:0] SOP     = 7'b0100011;
    localparam logic [6:0] IOP     = 7'b0010011;
    localparam logic [6:0] ROP     = 7'b0110011;

    // Default back-end structure sizes
    localparam int ROB_SIZE_DEF = 16;
    localparam int RS_SIZE_DEF  = 16;
    localparam int LSB_SIZE_DEF = 16;

    // One buffered fetch packet
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        jump_flag;
        logic [31:0] jump_pc;
    } iq_entry_t;

    // Which back-end structures an instruction will occupy
    typedef struct packed {
        logic rob;
        logic rs;
        logic lsb;
    } res_need_t;

    // Every instruction takes a ROB slot; ALU/branch ops add an RS slot;
    // memory ops add an RS slot and an LSB slot. Unknown opcodes are
    // treated like LUI so they still retire through the ROB.
    function automatic res_need_t classify(input logic [6:0] opcode);
        res_need_t need;
        need = '{rob: TRUE, rs: FALSE, lsb: FALSE};
        case (opcode)
            LUIOP, AUIPCOP, JALOP: need = '{rob: TRUE, rs: FALSE, lsb: FALSE};
            JALROP, BROP, IOP, ROP: need = '{rob: TRUE, rs: TRUE, lsb: FALSE};
            LOP, SOP:               need = '{rob: TRUE, rs: TRUE, lsb: TRUE};
            default:                need = '{rob: TRUE, rs: FALSE, lsb: FALSE};
        endcase
        return need;
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Fetch-side handshake and issue-side bus of the issue scheduler.
// master = fetcher/issue-stage environment, slave = the scheduler.
interface issue_scheduler_if;

    logic        if_valid;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        if_jump_flag;
    logic [31:0] if_jump_pc;
    logic        if_ready;

    logic        iss_sgn;
    logic [31:0] iss_ins;
    logic [31:0] iss_pc;
    logic        iss_jump_flag;
    logic [31:0] iss_jump_pc;

    modport master (
        output if_valid, if_ins, if_pc, if_jump_flag, if_jump_pc,
        input  if_ready,
        input  iss_sgn, iss_ins, iss_pc, iss_jump_flag, iss_jump_pc
    );

    modport slave (
        input  if_valid, if_ins, if_pc, if_jump_flag, if_jump_pc,
        output if_ready,
        output iss_sgn, iss_ins, iss_pc, iss_jump_flag, iss_jump_pc
    );

endinterface

// File: rtl/issue_scheduler_credit_counter.sv
// Saturating free-slot counter for one back-end structure. Starts full,
// decrements on take, increments on give, refills on flush, and flags a
// give that arrives while already full.
module credit_counter #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         flush,
    input  logic         take,
    input  logic         give,
    output logic [W-1:0] count,
    output logic         has_credit,
    output logic         overflow
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Net credit change; a give at MAX saturates instead of wrapping
    always_comb begin
        count_next = count_reg;
        if (take && !give) begin
            count_next = count_reg - W'(1);
        end else if (give && !take && (count_reg != MAX_C)) begin
            count_next = count_reg + W'(1);
        end
    end

    // Credit register: reset/flush refill, rdy low freezes
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= MAX_C;
        end else if (rdy) begin
            if (flush) begin
                count_reg <= MAX_C;
            end else begin
                count_reg <= count_next;
            end
        end
    end

    assign count      = count_reg;
    assign has_credit = (count_reg != '0);
    assign overflow   = rdy && !flush && give && !take && (count_reg == MAX_C);

endmodule

// File: rtl/issue_scheduler.sv
// In-order admission controller: buffers fetched instructions in a small
// FIFO and releases the head to the issue stage only when every back-end
// structure it needs has a guaranteed free slot.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int IQ_DEPTH = 4,
    parameter int ROB_SIZE = ROB_SIZE_DEF,
    parameter int RS_SIZE  = RS_SIZE_DEF,
    parameter int LSB_SIZE = LSB_SIZE_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    issue_scheduler_if.slave           bus,
    input  logic                       rob_release,
    input  logic                       rs_release,
    input  logic                       lsb_release,
    input  logic                       flush,
    output logic [$clog2(IQ_DEPTH):0]  iq_count,
    output logic                       credit_err
);

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    iq_entry_t            mem [IQ_DEPTH];
    logic [PTR_W-1:0]     head_reg;
    logic [PTR_W-1:0]     tail_reg;
    logic [CNT_W-1:0]     count_reg;

    iq_entry_t            iss_reg;
    logic                 iss_sgn_reg;
    logic                 credit_err_reg;

    iq_entry_t            in_entry;
    iq_entry_t            head_entry;
    res_need_t            need;
    logic                 push;
    logic                 pop;
    logic                 rob_has;
    logic                 rs_has;
    logic                 lsb_has;
    logic                 rob_ovf;
    logic                 rs_ovf;
    logic                 lsb_ovf;
    logic [$clog2(ROB_SIZE + 1)-1:0] rob_count;
    logic [$clog2(RS_SIZE + 1)-1:0]  rs_count;
    logic [$clog2(LSB_SIZE + 1)-1:0] lsb_count;

    assign bus.if_ready = (count_reg != CNT_W'(IQ_DEPTH));

    assign in_entry = '{ins: bus.if_ins, pc: bus.if_pc,
                        jump_flag: bus.if_jump_flag, jump_pc: bus.if_jump_pc};
    assign head_entry = mem[head_reg];

    // Head classification and in-order pop/push qualification
    always_comb begin
        need = classify(head_entry.ins[6:0]);
        push = rdy && !flush && bus.if_valid && bus.if_ready;
        pop  = rdy && !flush && (count_reg != '0)
            && (!need.rob || rob_has)
            && (!need.rs  || rs_has)
            && (!need.lsb || lsb_has);
    end

    // FIFO storage write at the tail
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[tail_reg] <= in_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (rdy) begin
            if (flush) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push) tail_reg <= tail_reg + PTR_W'(1);
                if (pop)  head_reg <= head_reg + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + CNT_W'(1);
                    2'b01:   count_reg <= count_reg - CNT_W'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // Issue output registers: one cycle from FIFO head to issue strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_sgn_reg <= 1'b0;
            iss_reg     <= '0;
        end else if (rdy) begin
            iss_sgn_reg <= pop;
            if (pop) begin
                iss_reg <= head_entry;
            end
        end
    end

    // Sticky over-release flag; flush leaves it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_err_reg <= 1'b0;
        end else if (rob_ovf || rs_ovf || lsb_ovf) begin
            credit_err_reg <= 1'b1;
        end
    end

    credit_counter #(.MAX(ROB_SIZE)) u_rob_credit (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .take(pop && need.rob), .give(rob_release),
        .count(rob_count), .has_credit(rob_has), .overflow(rob_ovf)
    );

    credit_counter #(.MAX(RS_SIZE)) u_rs_credit (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .take(pop && need.rs), .give(rs_release),
        .count(rs_count), .has_credit(rs_has), .overflow(rs_ovf)
    );

    credit_counter #(.MAX(LSB_SIZE)) u_lsb_credit (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .take(pop && need.lsb), .give(lsb_release),
        .count(lsb_count), .has_credit(lsb_has), .overflow(lsb_ovf)
    );

    assign bus.iss_sgn       = iss_sgn_reg;
    assign bus.iss_ins       = iss_reg.ins;
    assign bus.iss_pc        = iss_reg.pc;
    assign bus.iss_jump_flag = iss_reg.jump_flag;
    assign bus.iss_jump_pc   = iss_reg.jump_pc;
    assign iq_count          = count_reg;
    assign credit_err        = credit_err_reg;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed self-checking bench for issue_scheduler.
module tb_issue_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b1;
    logic       rob_release = 1'b0;
    logic       rs_release = 1'b0;
    logic       lsb_release = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] iq_count;
    logic       credit_err;

    int checks = 0;
    int errors = 0;
    int pulses;

    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] LUI  = 32'h1234_50B7;
    localparam logic [31:0] LW   = 32'h0000_A083;
    localparam logic [31:0] LW2  = 32'h0000_A103;
    localparam logic [31:0] ADD  = 32'h0020_81B3;

    issue_scheduler_if bus();

    issue_scheduler dut (
        .clk(clk), .rst(rst), .rdy(rdy), .bus(bus),
        .rob_release(rob_release), .rs_release(rs_release),
        .lsb_release(lsb_release), .flush(flush),
        .iq_count(iq_count), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        bus.if_valid     = v;
        bus.if_ins       = ins;
        bus.if_pc        = pc;
        bus.if_jump_flag = pc[2];
        bus.if_jump_pc   = pc + 32'd8;
    endtask

    task automatic credits(input string tag, input int rob, input int rs, input int lsb);
        $display("%s: rob=%0d rs=%0d lsb=%0d iq=%0d", tag, dut.rob_count, dut.rs_count, dut.lsb_count, iq_count);
        check({tag, "_rob"}, 32'(dut.rob_count), 32'(rob));
        check({tag, "_rs"},  32'(dut.rs_count),  32'(rs));
        check({tag, "_lsb"}, 32'(dut.lsb_count), 32'(lsb));
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0);
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_iq_count", 32'(iq_count), 32'd0);
        check("rst_if_ready", 32'(bus.if_ready), 32'd1);
        check("rst_iss_sgn", 32'(bus.iss_sgn), 32'd0);
        check("rst_iss_ins", bus.iss_ins, 32'd0);
        check("rst_iss_jpc", bus.iss_jump_pc, 32'd0);
        check("rst_credit_err", 32'(credit_err), 32'd0);
        credits("rst", 16, 16, 16);

        // Single ADDI: push, then issue one cycle later
        drive(1'b1, ADDI, 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("addi_push_count", 32'(iq_count), 32'd1);
        check("addi_push_sgn", 32'(bus.iss_sgn), 32'd0);
        step();
        $display("addi issue: sgn=%0d ins=%h", bus.iss_sgn, bus.iss_ins);
        check("addi_iss_sgn", 32'(bus.iss_sgn), 32'd1);
        check("addi_iss_ins", bus.iss_ins, ADDI);
        check("addi_iss_jpc", bus.iss_jump_pc, 32'd8);
        credits("addi", 15, 15, 16);
        step();
        check("addi_sgn_drop", 32'(bus.iss_sgn), 32'd0);
        rob_release = 1'b1; rs_release = 1'b1;
        step();
        rob_release = 1'b0; rs_release = 1'b0;

        // 17 LUIs: 16 issue, the 17th waits for a ROB credit
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, LUI, 32'(i * 4));
            step();
            pulses += int'(bus.iss_sgn);
        end
        drive(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(bus.iss_sgn);
        end
        $display("lui burst: pulses=%0d", pulses);
        check("lui_pulses", 32'(pulses), 32'd16);
        check("lui_stuck_count", 32'(iq_count), 32'd1);
        credits("lui_drained", 0, 16, 16);
        rob_release = 1'b1;
        step();
        rob_release = 1'b0;
        check("lui_release_sgn", 32'(bus.iss_sgn), 32'd0);
        step();
        check("lui17_sgn", 32'(bus.iss_sgn), 32'd1);
        check("lui17_pc", bus.iss_pc, 32'd64);
        check("lui17_count", 32'(iq_count), 32'd0);
        rob_release = 1'b1;
        for (int i = 0; i < 16; i++) step();
        rob_release = 1'b0;
        step();

        // Drain LSB credit, then LW blocks a younger ADD
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, LW, 32'h200 + 32'(i * 4));
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        step(); step();
        rob_release = 1'b1; rs_release = 1'b1;
        for (int i = 0; i < 16; i++) step();
        rob_release = 1'b0; rs_release = 1'b0;
        credits("lw_drained", 16, 16, 0);
        drive(1'b1, LW2, 32'h300);
        step();
        drive(1'b1, ADD, 32'h304);
        step();
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("block_count", 32'(iq_count), 32'd2);
        check("block_sgn", 32'(bus.iss_sgn), 32'd0);
        lsb_release = 1'b1;
        step();
        lsb_release = 1'b0;
        check("block_rel_sgn", 32'(bus.iss_sgn), 32'd0);
        step();
        $display("unblock lw: sgn=%0d ins=%h", bus.iss_sgn, bus.iss_ins);
        check("unblock_lw_sgn", 32'(bus.iss_sgn), 32'd1);
        check("unblock_lw_ins", bus.iss_ins, LW2);
        check("unblock_lw_count", 32'(iq_count), 32'd1);
        step();
        $display("unblock add: sgn=%0d ins=%h", bus.iss_sgn, bus.iss_ins);
        check("unblock_add_sgn", 32'(bus.iss_sgn), 32'd1);
        check("unblock_add_ins", bus.iss_ins, ADD);
        check("unblock_add_pc", bus.iss_pc, 32'h304);
        credits("unblock", 14, 14, 0);
        step();

        // Bring ROB credit to 3, then pop and release in the same cycle
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, LUI, 32'h400 + 32'(i * 4));
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        step(); step();
        credits("rob3", 3, 14, 0);
        drive(1'b1, LUI, 32'h500);
        step();
        drive(1'b0, 32'h0, 32'h0);
        rob_release = 1'b1;
        step();
        rob_release = 1'b0;
        check("poprel_sgn", 32'(bus.iss_sgn), 32'd1);
        credits("poprel", 3, 14, 0);
        step();
        for (int i = 0; i < 16; i++) begin
            rob_release = (i < 13);
            rs_release  = (i < 2);
            lsb_release = 1'b1;
            step();
        end
        rob_release = 1'b0; rs_release = 1'b0; lsb_release = 1'b0;
        credits("refill", 16, 16, 16);
        check("refill_credit_err", 32'(credit_err), 32'd0);
        rob_release = 1'b1;
        step();
        rob_release = 1'b0;
        check("overflow_credit_err", 32'(credit_err), 32'd1);
        credits("overflow", 16, 16, 16);

        // Fill the FIFO behind exhausted credits, then flush with a push
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, LW, 32'h600 + 32'(i * 4));
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        step(); step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, LUI, 32'h700 + 32'(i * 4));
            step();
        end
        check("full_count", 32'(iq_count), 32'd4);
        check("full_if_ready", 32'(bus.if_ready), 32'd0);
        drive(1'b1, LUI, 32'h710);
        step();
        check("full_push5_count", 32'(iq_count), 32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("flush_count", 32'(iq_count), 32'd0);
        check("flush_sgn", 32'(bus.iss_sgn), 32'd0);
        check("flush_if_ready", 32'(bus.if_ready), 32'd1);
        check("flush_credit_err", 32'(credit_err), 32'd1);
        credits("flush", 16, 16, 16);

        // rdy low freezes everything, including a pending issue strobe
        drive(1'b1, ADDI, 32'h100);
        step();
        drive(1'b1, ADDI, 32'h104);
        step();
        check("pre_stall_sgn", 32'(bus.iss_sgn), 32'd1);
        check("pre_stall_pc", bus.iss_pc, 32'h100);
        rdy = 1'b0;
        rob_release = 1'b1;
        drive(1'b1, ADDI, 32'h108);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_count", 32'(iq_count), 32'd1);
            check("stall_sgn", 32'(bus.iss_sgn), 32'd1);
            check("stall_pc", bus.iss_pc, 32'h100);
            credits("stall", 15, 15, 16);
        end
        rdy = 1'b1;
        rob_release = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("resume_sgn", 32'(bus.iss_sgn), 32'd1);
        check("resume_pc", bus.iss_pc, 32'h104);
        check("resume_count", 32'(iq_count), 32'd0);
        credits("resume", 14, 14, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
In-order admission controller between the instruction fetcher and the issue/decode stage of the Tomasulo core. It buffers fetched instructions in a small FIFO. It releases one instruction per cycle to the issue stage only when the resources that instruction class needs have a guaranteed free slot. Free slots in the ROB, RS and LSB are tracked with credit counters. Flush on misprediction empties the FIFO and restores all credits.

Parameters:
IQ_DEPTH, 4, instruction FIFO entries (power of two)
ROB_SIZE, 16, ROB entries; initial and maximum ROB credit
RS_SIZE, 16, reservation-station entries; initial and maximum RS credit
LSB_SIZE, 16, load/store-buffer entries; initial and maximum LSB credit

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; low freezes all state
if_valid  in  1  fetcher presents an instruction this cycle
if_ins  in  32  instruction word
if_pc  in  32  instruction PC
if_jump_flag  in  1  predicted-taken flag
if_jump_pc  in  32  predicted target / link PC
if_ready  out  1  FIFO can accept (count < IQ_DEPTH)
iss_sgn  out  1  registered issue strobe to the issue stage
iss_ins  out  32  issued instruction
iss_pc  out  32  issued PC
iss_jump_flag  out  1  issued prediction flag
iss_jump_pc  out  32  issued target
rob_release  in  1  one ROB entry committed and freed
rs_release  in  1  one RS entry dispatched and freed
lsb_release  in  1  one LSB entry retired and freed
flush  in  1  misprediction clear from the ROB
iq_count  out  clog2(IQ_DEPTH)+1  FIFO occupancy
credit_err  out  1  sticky: a release arrived with credit already at maximum

Behaviour:
- Reset:
  - FIFO is empty; iq_count=0; if_ready=1.
  - iss_sgn=0 and all iss_* data outputs are 0.
  - Credits: rob=ROB_SIZE, rs=RS_SIZE, lsb=LSB_SIZE.
  - credit_err=0.
- Push: when if_valid && if_ready, write the instruction at the tail. if_ready depends only on count, never on the same-cycle pop.
- Classification of the head instruction (opcode bits [6:0]):
  - LUI, AUIPC, JAL: need ROB only.
  - JALR, BRANCH, OP-IMM, OP: need ROB and RS.
  - LOAD, STORE: need ROB, RS and LSB.
  - Any other opcode: needs ROB only.
- Pop: the head pops when the FIFO is non-empty and every needed credit is ≥1.
  - Pop loads the iss_* registers and sets iss_sgn=1 on the next edge, i.e. one cycle of latency from FIFO head to issue.
  - Otherwise iss_sgn=0 on that edge and the iss_* data registers hold.
- Ordering: strictly in order. A blocked head blocks all younger entries, with no bypass.
- Credits: next = credit − (pop && needed) + release, for each counter independently.
  - A simultaneous pop and release of the same counter leaves it unchanged.
  - A release with credit == max and no pop saturates at max and sets credit_err.
- Issue throughput: at most one instruction per cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - The FIFO pointers wrap modulo IQ_DEPTH.
- Flush (highest priority after rst):
  - Empties the FIFO; the same-cycle push is dropped.
  - iss_sgn=0 next cycle.
  - All credits return to maximum; same-cycle releases are ignored.
  - credit_err holds.
- rdy low:
  - All registers hold, including iss_sgn. Consumers are also rdy-gated, so no duplicate issue occurs.
  - Releases and pushes in that cycle are ignored.
- rst during operation takes effect on the next edge regardless of rdy or flush.

Decomposition:
- Shared defines header: RV32I major opcode constants (LUIOP, AUIPCOP, JALOP, JALROP, BROP, LOP, SOP, IOP, ROP), the True/False macros, and the ROB/RS/LSB size constants used as parameter defaults.
- One natural sub-module: credit_counter. It has parameter MAX, inputs take/give, outputs count/has_credit/overflow, and is instantiated three times.
- FIFO and classification logic stay inline.

Test Plan:
- Reset, then push ADDI 0x00100093 at PC 0 → next edge iq_count=1; the following edge iss_sgn=1, iss_ins=0x00100093; rob and rs credits 15, lsb credit 16.
- Issue 16 LUIs with no releases → 16 iss_sgn pulses and rob credit 0. The 17th LUI stays in the FIFO. One rob_release → it issues on the following cycle.
- Drain LSB credit to 0 with 16 LW, then push LW then ADD → neither issues (in-order block). One lsb_release → LW issues, then ADD issues the next cycle.
- With rob credit 3, assert a pop and rob_release in the same cycle → rob credit stays 3. rob_release at credit 16 → stays 16 and credit_err=1.
- Fill the FIFO (4 entries, issue blocked by zero credit) → if_ready=0 and a 5th push is ignored. Then assert flush with a simultaneous push → iq_count=0, all credits at maximum, iss_sgn=0 next cycle.
- Hold rdy low for 3 cycles with a valid pushable head → iq_count, credits and iss_* are unchanged. After rdy rises, issue resumes within 1 cycle.
